// File: rtl/writeback_arbiter_if.sv
// Signal bundle between the writeback buffer, long-latency unit and register-file port.
// The master side drives requests; the slave side (the arbiter) drives the write port.
interface writeback_arbiter_if #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 5
) ();
  logic              wb_regwrite;
  logic [ADDR_W-1:0] wb_addr;
  logic [DATA_W-1:0] wb_data;
  logic              wb_setflags;
  logic [3:0]        wb_flags;
  logic              lu_valid;
  logic              lu_ready;
  logic [ADDR_W-1:0] lu_addr;
  logic [DATA_W-1:0] lu_data;
  logic              rf_we;
  logic [ADDR_W-1:0] rf_addr;
  logic [DATA_W-1:0] rf_data;
  logic              flags_we;
  logic [3:0]        flags_out;
  logic              halt;
  logic [1:0]        fifo_count;

  modport master (
    output wb_regwrite, wb_addr, wb_data, wb_setflags, wb_flags,
    output lu_valid, lu_addr, lu_data,
    input  lu_ready, rf_we, rf_addr, rf_data, flags_we, flags_out, halt, fifo_count
  );

  modport slave (
    input  wb_regwrite, wb_addr, wb_data, wb_setflags, wb_flags,
    input  lu_valid, lu_addr, lu_data,
    output lu_ready, rf_we, rf_addr, rf_data, flags_we, flags_out, halt, fifo_count
  );
endinterface

// File: rtl/writeback_arbiter.sv
// Shares the register-file write port between the pipeline (priority) and a 2-entry
// FIFO of long-latency results; a one-cycle halt steals the port when the FIFO starves.
module writeback_arbiter #(
  parameter int DATA_W       = 64,
  parameter int ADDR_W       = 5,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                clk,
  input  logic                rst,
  writeback_arbiter_if.slave  bus
);

  localparam int              CNT_W    = $clog2(STARVE_LIMIT + 1);
  localparam logic [0:0]      ST_PASS  = 1'b0;
  localparam logic [0:0]      ST_STEAL = 1'b1;
  localparam logic [ADDR_W-1:0] XZR    = ADDR_W'(31);
  localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(STARVE_LIMIT);
  localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

  logic [0:0]        r_state;
  logic              r_halt;
  logic [1:0]        r_count;
  logic              r_rd_ptr;
  logic              r_wr_ptr;
  logic [CNT_W-1:0]  r_starve_cnt;
  logic [ADDR_W-1:0] r_fifo_addr [2];
  logic [DATA_W-1:0] r_fifo_data [2];

  logic              w_nonempty;
  logic              w_full;
  logic              w_pipe_win;
  logic              w_fifo_win;
  logic              w_starving;
  logic              w_steal_req;
  logic              w_push;
  logic              w_lu_ready;
  logic [0:0]        w_next_state;
  logic [ADDR_W-1:0] w_win_addr;
  logic [DATA_W-1:0] w_win_data;

  // Port arbitration, FIFO handshake and steal decision.
  always_comb begin
    w_nonempty  = (r_count != 2'd0);
    w_full      = (r_count == 2'd2);
    w_pipe_win  = (r_state == ST_PASS) && bus.wb_regwrite;
    w_fifo_win  = w_nonempty && !w_pipe_win;
    w_starving  = w_pipe_win && w_nonempty;
    w_lu_ready  = rst && !w_full;
    w_push      = bus.lu_valid && w_lu_ready;
    // Steal on the LIMIT-th consecutive starved cycle, or when a result is stuck behind a full FIFO.
    w_steal_req = w_pipe_win &&
                  ((w_starving && ((r_starve_cnt + ONE_C) == LIMIT_C)) ||
                   (w_full && bus.lu_valid));
    case (r_state)
      ST_PASS:  w_next_state = w_steal_req ? ST_STEAL : ST_PASS;
      ST_STEAL: w_next_state = ST_PASS;
      default:  w_next_state = ST_PASS;
    endcase
    if (w_pipe_win) begin
      w_win_addr = bus.wb_addr;
      w_win_data = bus.wb_data;
    end else begin
      w_win_addr = r_fifo_addr[r_rd_ptr];
      w_win_data = r_fifo_data[r_rd_ptr];
    end
  end

  // Drive the register-file and flags ports.
  always_comb begin
    bus.rf_we      = (w_pipe_win || w_fifo_win) && (w_win_addr != XZR);
    bus.rf_addr    = w_win_addr;
    bus.rf_data    = w_win_data;
    bus.flags_we   = (r_state == ST_PASS) && bus.wb_setflags;
    bus.flags_out  = bus.wb_flags;
    bus.lu_ready   = w_lu_ready;
    bus.halt       = r_halt;
    bus.fifo_count = r_count;
  end

  // State, occupancy, pointers and starvation counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= ST_PASS;
      r_halt       <= 1'b0;
      r_count      <= 2'd0;
      r_rd_ptr     <= 1'b0;
      r_wr_ptr     <= 1'b0;
      r_starve_cnt <= '0;
    end else begin
      r_state <= w_next_state;
      r_halt  <= (w_next_state == ST_STEAL);
      case ({w_push, w_fifo_win})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
      if (w_push) begin
        r_wr_ptr <= ~r_wr_ptr;
      end
      if (w_fifo_win) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      if (w_next_state == ST_STEAL) begin
        r_starve_cnt <= '0;
      end else if (w_starving) begin
        r_starve_cnt <= (r_starve_cnt == LIMIT_C) ? LIMIT_C : (r_starve_cnt + ONE_C);
      end else begin
        r_starve_cnt <= '0;
      end
    end
  end

  // FIFO storage; contents are don't-care after reset.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_addr[r_wr_ptr] <= bus.lu_addr;
      r_fifo_data[r_wr_ptr] <= bus.lu_data;
    end
  end

endmodule

// File: tb/tb_writeback_arbiter.sv
// Directed self-checking bench for writeback_arbiter with STARVE_LIMIT = 4.
module tb_writeback_arbiter;

  logic clk;
  logic rst;
  int   n_chk;
  int   n_fail;

  writeback_arbiter_if #(.DATA_W(64), .ADDR_W(5)) bus ();

  writeback_arbiter #(.DATA_W(64), .ADDR_W(5), .STARVE_LIMIT(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle_inputs();
    bus.wb_regwrite = 1'b0; bus.wb_addr = 5'd0; bus.wb_data = 64'd0;
    bus.wb_setflags = 1'b0; bus.wb_flags = 4'd0;
    bus.lu_valid = 1'b0; bus.lu_addr = 5'd0; bus.lu_data = 64'd0;
  endtask

  task automatic test_reset();
    #2;
    n_chk++; if (bus.fifo_count !== 2'd0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", bus.fifo_count); end
    n_chk++; if (bus.halt !== 1'b0) begin n_fail++; $display("FAIL reset_halt: got %0b expected 0", bus.halt); end
    n_chk++; if (bus.lu_ready !== 1'b0) begin n_fail++; $display("FAIL reset_lu_ready: got %0b expected 0", bus.lu_ready); end
    @(negedge clk); rst = 1'b1; #1;
    n_chk++; if (bus.lu_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_lu_ready: got %0b expected 1", bus.lu_ready); end
    n_chk++; if (bus.rf_we !== 1'b0) begin n_fail++; $display("FAIL post_reset_rf_we: got %0b expected 0", bus.rf_we); end
    @(negedge clk);
  endtask

  task automatic test_idle_pipe();
    bus.lu_valid = 1'b1; bus.lu_addr = 5'd3; bus.lu_data = 64'hA; #1;
    n_chk++; if (bus.rf_we !== 1'b0) begin n_fail++; $display("FAIL idle_no_bypass: got %0b expected 0", bus.rf_we); end
    @(negedge clk); bus.lu_valid = 1'b0; #1;
    n_chk++; if (bus.rf_we !== 1'b1) begin n_fail++; $display("FAIL idle_rf_we: got %0b expected 1", bus.rf_we); end
    n_chk++; if (bus.rf_addr !== 5'd3) begin n_fail++; $display("FAIL idle_rf_addr: got %0d expected 3", bus.rf_addr); end
    n_chk++; if (bus.rf_data !== 64'hA) begin n_fail++; $display("FAIL idle_rf_data: got %0h expected a", bus.rf_data); end
    @(negedge clk); #1;
    n_chk++; if (bus.fifo_count !== 2'd0) begin n_fail++; $display("FAIL idle_count: got %0d expected 0", bus.fifo_count); end
    @(negedge clk);
  endtask

  task automatic test_starvation();
    bus.wb_regwrite = 1'b1; bus.wb_addr = 5'd2; bus.wb_data = 64'h11;
    bus.wb_setflags = 1'b1; bus.wb_flags = 4'h5;
    bus.lu_valid = 1'b1; bus.lu_addr = 5'd7; bus.lu_data = 64'hB0; #1;
    n_chk++; if (bus.flags_we !== 1'b1 || bus.flags_out !== 4'h5) begin n_fail++; $display("FAIL pass_flags: got we=%0b val=%0h expected we=1 val=5", bus.flags_we, bus.flags_out); end
    @(negedge clk); bus.lu_valid = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      #1;
      n_chk++; if (bus.halt !== 1'b0 || bus.rf_addr !== 5'd2 || bus.rf_we !== 1'b1) begin n_fail++; $display("FAIL starve_pipe_wins_c%0d: got halt=%0b addr=%0d we=%0b expected halt=0 addr=2 we=1", c, bus.halt, bus.rf_addr, bus.rf_we); end
      @(negedge clk);
    end
    #1;
    n_chk++; if (bus.halt !== 1'b1) begin n_fail++; $display("FAIL steal_halt: got %0b expected 1", bus.halt); end
    n_chk++; if (bus.rf_we !== 1'b1 || bus.rf_addr !== 5'd7 || bus.rf_data !== 64'hB0) begin n_fail++; $display("FAIL steal_write: got we=%0b addr=%0d data=%0h expected we=1 addr=7 data=b0", bus.rf_we, bus.rf_addr, bus.rf_data); end
    n_chk++; if (bus.flags_we !== 1'b0) begin n_fail++; $display("FAIL steal_flags_we: got %0b expected 0", bus.flags_we); end
    @(negedge clk); #1;
    n_chk++; if (bus.halt !== 1'b0) begin n_fail++; $display("FAIL after_steal_halt: got %0b expected 0", bus.halt); end
    n_chk++; if (bus.rf_addr !== 5'd2 || bus.rf_data !== 64'h11 || bus.fifo_count !== 2'd0) begin n_fail++; $display("FAIL held_pipe_write: got addr=%0d data=%0h cnt=%0d expected addr=2 data=11 cnt=0", bus.rf_addr, bus.rf_data, bus.fifo_count); end
    @(negedge clk); idle_inputs();
    @(negedge clk);
  endtask

  task automatic test_full_fifo();
    bus.wb_regwrite = 1'b1; bus.wb_addr = 5'd4; bus.wb_data = 64'h44;
    bus.lu_valid = 1'b1; bus.lu_addr = 5'd8; bus.lu_data = 64'hC1;
    @(negedge clk); bus.lu_addr = 5'd9; bus.lu_data = 64'hC2; #1;
    n_chk++; if (bus.lu_ready !== 1'b1) begin n_fail++; $display("FAIL full_ready_one: got %0b expected 1", bus.lu_ready); end
    @(negedge clk); bus.lu_addr = 5'd10; bus.lu_data = 64'hC3; #1;
    n_chk++; if (bus.fifo_count !== 2'd2 || bus.lu_ready !== 1'b0) begin n_fail++; $display("FAIL full_not_ready: got cnt=%0d ready=%0b expected cnt=2 ready=0", bus.fifo_count, bus.lu_ready); end
    n_chk++; if (bus.halt !== 1'b0 || bus.rf_addr !== 5'd4) begin n_fail++; $display("FAIL full_pipe_wins: got halt=%0b addr=%0d expected halt=0 addr=4", bus.halt, bus.rf_addr); end
    @(negedge clk); #1;
    n_chk++; if (bus.halt !== 1'b1 || bus.rf_addr !== 5'd8 || bus.rf_data !== 64'hC1) begin n_fail++; $display("FAIL full_steal_pop: got halt=%0b addr=%0d data=%0h expected halt=1 addr=8 data=c1", bus.halt, bus.rf_addr, bus.rf_data); end
    n_chk++; if (bus.lu_ready !== 1'b0) begin n_fail++; $display("FAIL full_no_bypass: got %0b expected 0", bus.lu_ready); end
    @(negedge clk); #1;
    n_chk++; if (bus.halt !== 1'b0 || bus.lu_ready !== 1'b1 || bus.fifo_count !== 2'd1) begin n_fail++; $display("FAIL full_reopen: got halt=%0b ready=%0b cnt=%0d expected halt=0 ready=1 cnt=1", bus.halt, bus.lu_ready, bus.fifo_count); end
    @(negedge clk); idle_inputs(); #1;
    n_chk++; if (bus.fifo_count !== 2'd2 || bus.rf_addr !== 5'd9 || bus.rf_data !== 64'hC2) begin n_fail++; $display("FAIL full_drain1: got cnt=%0d addr=%0d data=%0h expected cnt=2 addr=9 data=c2", bus.fifo_count, bus.rf_addr, bus.rf_data); end
    @(negedge clk); #1;
    n_chk++; if (bus.rf_we !== 1'b1 || bus.rf_addr !== 5'd10 || bus.rf_data !== 64'hC3) begin n_fail++; $display("FAIL full_drain2: got we=%0b addr=%0d data=%0h expected we=1 addr=10 data=c3", bus.rf_we, bus.rf_addr, bus.rf_data); end
    @(negedge clk); #1;
    n_chk++; if (bus.fifo_count !== 2'd0) begin n_fail++; $display("FAIL full_empty: got %0d expected 0", bus.fifo_count); end
    @(negedge clk);
  endtask

  task automatic test_xzr();
    bus.wb_regwrite = 1'b1; bus.wb_addr = 5'd31; bus.wb_data = 64'hFF;
    bus.lu_valid = 1'b1; bus.lu_addr = 5'd31; bus.lu_data = 64'hEE; #1;
    n_chk++; if (bus.rf_we !== 1'b0) begin n_fail++; $display("FAIL xzr_pipe_we: got %0b expected 0", bus.rf_we); end
    @(negedge clk); idle_inputs(); #1;
    n_chk++; if (bus.rf_we !== 1'b0 || bus.fifo_count !== 2'd1) begin n_fail++; $display("FAIL xzr_fifo_we: got we=%0b cnt=%0d expected we=0 cnt=1", bus.rf_we, bus.fifo_count); end
    @(negedge clk); #1;
    n_chk++; if (bus.fifo_count !== 2'd0) begin n_fail++; $display("FAIL xzr_pop: got %0d expected 0", bus.fifo_count); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    bus.lu_valid = 1'b1; bus.lu_addr = 5'd12; bus.lu_data = 64'hD1;
    @(negedge clk); bus.lu_addr = 5'd13; bus.lu_data = 64'hD2; #1;
    n_chk++; if (bus.rf_we !== 1'b1 || bus.rf_addr !== 5'd12 || bus.rf_data !== 64'hD1) begin n_fail++; $display("FAIL pushpop_head: got we=%0b addr=%0d data=%0h expected we=1 addr=12 data=d1", bus.rf_we, bus.rf_addr, bus.rf_data); end
    @(negedge clk); idle_inputs(); #1;
    n_chk++; if (bus.fifo_count !== 2'd1 || bus.rf_addr !== 5'd13 || bus.rf_data !== 64'hD2) begin n_fail++; $display("FAIL pushpop_next: got cnt=%0d addr=%0d data=%0h expected cnt=1 addr=13 data=d2", bus.fifo_count, bus.rf_addr, bus.rf_data); end
    @(negedge clk); #1;
    n_chk++; if (bus.fifo_count !== 2'd0) begin n_fail++; $display("FAIL pushpop_empty: got %0d expected 0", bus.fifo_count); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    bus.wb_regwrite = 1'b1; bus.wb_addr = 5'd1; bus.wb_data = 64'h1;
    bus.lu_valid = 1'b1; bus.lu_addr = 5'd20; bus.lu_data = 64'hE1;
    @(negedge clk); bus.lu_addr = 5'd21; bus.lu_data = 64'hE2;
    @(negedge clk); bus.lu_valid = 1'b0; #1;
    n_chk++; if (bus.fifo_count !== 2'd2) begin n_fail++; $display("FAIL mid_prefill: got %0d expected 2", bus.fifo_count); end
    #1; rst = 1'b0; #1;
    n_chk++; if (bus.fifo_count !== 2'd0 || bus.halt !== 1'b0 || bus.lu_ready !== 1'b0) begin n_fail++; $display("FAIL mid_reset: got cnt=%0d halt=%0b ready=%0b expected 0 0 0", bus.fifo_count, bus.halt, bus.lu_ready); end
    @(negedge clk); rst = 1'b1; idle_inputs();
    for (int c = 0; c < 3; c++) begin
      #1;
      n_chk++; if (bus.rf_we !== 1'b0 || bus.fifo_count !== 2'd0) begin n_fail++; $display("FAIL mid_discard_c%0d: got we=%0b cnt=%0d expected we=0 cnt=0", c, bus.rf_we, bus.fifo_count); end
      @(negedge clk);
    end
  endtask

  initial begin
    n_chk = 0;
    n_fail = 0;
    rst = 1'b0;
    idle_inputs();
    test_reset();
    test_idle_pipe();
    test_starvation();
    test_full_fifo();
    test_xzr();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
